// File: rtl/script_loader.sv
// Script download writer: parses HDR/N/words/CHK frames from the UART byte
// stream, writes 16-bit words to script memory at even byte addresses and
// reports busy/done/err status with an inter-byte timeout.
module script_loader #(
  parameter logic [7:0]  HDR       = 8'hA5,
  parameter int          MAX_WORDS = 128,
  parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        res,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_count
);

  localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CHK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  hi_q, hi_d;
  logic [6:0]  idx_q, idx_d;
  logic [23:0] timer_q, timer_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  wc_q, wc_d;

  logic timeout_hit;
  logic len_bad;
  logic last_word;

  // A received byte in the same cycle always wins over the timeout.
  assign timeout_hit = (state_q != S_IDLE) && !rx_valid && ((timer_q + 24'd1) == TIMEOUT);
  assign len_bad     = (rx_data == 8'd0) || ({1'b0, rx_data} > MAX_W);
  assign last_word   = ({1'b0, idx_q} == (n_q - 8'd1));

  // State and datapath registers, all cleared by the async reset.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_IDLE;
      n_q       <= 8'd0;
      chk_q     <= 8'd0;
      hi_q      <= 8'd0;
      idx_q     <= 7'd0;
      timer_q   <= 24'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wc_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      chk_q     <= chk_d;
      hi_q      <= hi_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wc_q      <= wc_d;
    end
  end

  // Next-state: advance one step per received byte, or drop to IDLE on timeout.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE:  state_d = (rx_data == HDR) ? S_LEN : S_IDLE;
        S_LEN:   state_d = len_bad ? S_IDLE : S_HI;
        S_HI:    state_d = S_LO;
        S_LO:    state_d = last_word ? S_CHK : S_HI;
        S_CHK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values: word assembly, checksum, status flags.
  always_comb begin
    n_d       = n_q;
    chk_d     = chk_q;
    hi_d      = hi_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    wc_d      = wc_q;
    timer_d   = (state_q == S_IDLE || rx_valid || timeout_hit) ? 24'd0 : timer_q + 24'd1;
    if (timeout_hit) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == HDR) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            busy_d = 1'b1;
            wc_d   = 8'd0;
          end
        end
        S_LEN: begin
          if (len_bad) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
          end else begin
            n_d   = rx_data;
            chk_d = rx_data;
            idx_d = 7'd0;
          end
        end
        S_HI: begin
          hi_d  = rx_data;
          chk_d = chk_q ^ rx_data;
        end
        S_LO: begin
          chk_d     = chk_q ^ rx_data;
          wr_en_d   = 1'b1;
          wr_data_d = {hi_q, rx_data};
          wr_addr_d = {idx_q, 1'b0};
          wc_d      = {1'b0, idx_q} + 8'd1;
          if (!last_word) idx_d = idx_q + 7'd1;
        end
        S_CHK: begin
          if (rx_data == chk_q) done_d = 1'b1;
          else                  err_d  = 1'b1;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule

// File: doc/script_loader.md
Name: script_loader

Overview:
- Writer side of the script memory: receives a framed script download as a byte stream from the UART receiver.
- Assembles 16-bit script words and writes them into script memory at the byte addresses the script decoder fetches from (0, 2, 4, ...).
- Reports the download status. While busy is asserted, the integration holds the decoder's pc in reset.

Parameters:
- HDR, 8'hA5, frame header byte.
- MAX_WORDS, 128, maximum words per frame (addresses 0..254).
- TIMEOUT, 24'd10_000_000, inter-byte timeout in clk cycles while a frame is open.

Ports:
- clk  in  1  system clock.
- res  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back strobes are legal.
- wr_en  out  1  script memory write strobe, exactly one cycle per word.
- wr_addr  out  8  script memory byte address (word index << 1).
- wr_data  out  16  script word: {i_num, i_sign, func, op_code}.
- busy  out  1  a frame is open (LEN through CHK).
- done  out  1  sticky: last frame completed with a good checksum.
- err  out  1  sticky: last frame aborted (bad length, bad checksum or timeout).
- word_count  out  8  words written in the current or last frame.

Behaviour:
- Frame format: HDR, N, then N word pairs (high byte first, i.e. script[15:8], then script[7:0]), then CHK. CHK = N XOR all 2N data bytes.
- Reset (res=0, async): state IDLE. wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, word_count=0. Internal index, checksum and timer are cleared.
- The FSM acts only on cycles with rx_valid=1, except for the timeout.
- States and transitions:
  - IDLE: byte==HDR → LEN; clear done and err; set busy; clear word_count. Any other byte is ignored.
  - LEN: N==0 or N>MAX_WORDS → set err, clear busy, go to IDLE. Otherwise latch N, set chk=N, idx=0, go to HI.
  - HI: latch hi=byte; chk^=byte; go to LO.
  - LO: chk^=byte. On the next clk edge: wr_en=1 for exactly one cycle, wr_data={hi,byte}, wr_addr={idx[6:0],1'b0}, word_count=idx+1. Then idx==N-1 → CHK, else idx++ and → HI.
  - CHK: byte==chk → set done; otherwise set err. Clear busy and go to IDLE; both take effect on the next edge.
- Write latency: wr_en is high the cycle after the LO byte's rx_valid cycle. Back-to-back bytes can produce a write every 2 cycles at most. Each write is independent of the next byte.
- Bytes equal to HDR inside an open frame are treated as data; there is no resynchronisation.
- Timeout: a counter runs in LEN/HI/LO/CHK and clears on every rx_valid. When it reaches TIMEOUT: set err, clear busy, go to IDLE. The counter is held at 0 in IDLE.
- Simultaneous events: if rx_valid arrives in the same cycle the counter reaches TIMEOUT, the byte wins and the counter clears.
- Words already written stay in memory after an error or a mid-frame reset; no rollback.
- done and err are never set together. Both hold until the next HDR in IDLE, or reset.
- word_count is 8 bits wide; maximum value is MAX_WORDS. wr_addr does not wrap for legal N.

Test Plan:
1. Reset, then send A5 02 12 01 34 05 CHK=(02^12^01^34^05=0x20).
   - Writes 0x1201@0 and 0x3405@2, each a one-cycle wr_en.
   - done=1, err=0, word_count=2, busy=0.
2. Same frame with CHK=0x21.
   - Both writes still occur; err=1, done=0.
3. Send A5 00, then separately A5 81 (129 > MAX_WORDS).
   - err=1 in each case, no wr_en, FSM returns to IDLE.
4. Send 55 A5 01 A5 A5 then CHK=01.
   - 0x55 is ignored; writes 0xA5A5@0; done=1 (01^A5^A5=01).
5. Sim with TIMEOUT=16: send A5 03 10 then stall.
   - err=1 exactly 16 cycles after the last rx_valid; busy falls; no write.
   - A following full frame then succeeds.
6. Assert res low mid-frame, after the HI byte.
   - All outputs are 0 immediately, with no pending wr_en.
   - A fresh frame A5 01 00 07 CHK=06 writes 0x0007@0 and sets done=1.
